input_arbiter: RTL and testbench

Merges the PS/2 keyboard byte stream and the UART receive byte stream into one buffered input channel for the 6502. Each source uses a valid/ready handshake. A round-robin grant selects at most one byte per cycle and writes it into a FIFO. Each FIFO entry stores the byte plus a source tag. The CPU reads the FIFO through a two-register memory-mapped port, and an interrupt line flags pending input.

---
 rtl/input_arbiter.sv | 123 ++++++++++++
 tb/tb_input_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/input_arbiter.sv
// Merges keyboard and UART byte streams into one tagged FIFO read by the CPU.
// Define KBD_PRIORITY_EN for fixed keyboard priority instead of round-robin.
module input_arbiter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic       uart_ready,
  input  logic       cpu_addr,
  input  logic       cpu_rd,
  output logic [7:0] cpu_rdata,
  output logic       irq
);

  localparam int unsigned EW = 9;
  localparam int unsigned CW = AW + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [EW-1:0] head;
  logic [EW-1:0] wr_entry;
  logic [7:0]    rdata_nxt;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          grant_kbd;
  logic          grant_uart;
  logic          push;
  logic          pop;
`ifndef KBD_PRIORITY_EN
  logic          last_grant;
`endif

  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count == CW'(DEPTH - 1));
  assign empty       = (count == '0);
  assign head        = mem[rd_ptr];

  // Grant: readies stay low in reset and whenever the FIFO is full.
  always_comb begin
    grant_kbd  = 1'b0;
    grant_uart = 1'b0;
    if (!reset && !full) begin
`ifdef KBD_PRIORITY_EN
      grant_kbd  = kbd_valid;
      grant_uart = uart_valid & ~kbd_valid;
`else
      grant_kbd  = kbd_valid  & (~uart_valid | last_grant);
      grant_uart = uart_valid & (~kbd_valid  | ~last_grant);
`endif
    end
  end

  assign kbd_ready  = grant_kbd;
  assign uart_ready = grant_uart;
  assign push       = grant_kbd | grant_uart;
  assign pop        = cpu_rd & cpu_addr & ~empty;
  assign wr_entry   = grant_uart ? {1'b1, uart_data} : {1'b0, kbd_data};

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Read mux: STATUS is side-effect free, DATA on empty returns zero.
  always_comb begin
    rdata_nxt = cpu_rdata;
    if (cpu_rd) begin
      if (cpu_addr) begin
        rdata_nxt = pop ? head[7:0] : 8'h00;
      end else begin
        rdata_nxt = {head[8] & ~empty, 4'b0000, almost_full, full, ~empty};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cpu_rdata  <= 8'h00;
      irq        <= 1'b0;
`ifndef KBD_PRIORITY_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
`ifndef KBD_PRIORITY_EN
        last_grant <= grant_uart;
`endif
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      cpu_rdata <= rdata_nxt;
      irq       <= (count_nxt != '0);
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_input_arbiter.sv
// Directed vector bench for input_arbiter with a queue model for the wrap test.
module tb_input_arbiter;

`ifdef KBD_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_valid = 1'b0;
  logic       kbd_ready;
  logic [7:0] uart_data = 8'h00;
  logic       uart_valid = 1'b0;
  logic       uart_ready;
  logic       cpu_addr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic [7:0] cpu_rdata;
  logic       irq;

  int errors = 0;
  int checks = 0;

  input_arbiter #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .uart_data(uart_data), .uart_valid(uart_valid), .uart_ready(uart_ready),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       kv;
    logic [7:0] kd;
    logic       uv;
    logic [7:0] ud;
    logic       rd;
    logic       addr;
    logic       ekr;
    logic       eur;
    logic [7:0] erd;
    logic       eirq;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic kv, input logic [7:0] kd,
                              input logic uv, input logic [7:0] ud, input logic rd,
                              input logic addr, input logic ekr, input logic eur,
                              input logic [7:0] erd, input logic eirq);
    vec_t v;
    v.rst = rst; v.kv = kv; v.kd = kd; v.uv = uv; v.ud = ud; v.rd = rd;
    v.addr = addr; v.ekr = ekr; v.eur = eur; v.erd = erd; v.eirq = eirq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One clock: readies checked before the edge, registered outputs after it.
  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; kbd_valid = v.kv; kbd_data = v.kd;
    uart_valid = v.uv; uart_data = v.ud; cpu_rd = v.rd; cpu_addr = v.addr;
    #1;
    chk({tag, " kbd_ready"}, 8'(kbd_ready), 8'(v.ekr));
    chk({tag, " uart_ready"}, 8'(uart_ready), 8'(v.eur));
    @(posedge clk);
    #1;
    chk({tag, " cpu_rdata"}, cpu_rdata, v.erd);
    chk({tag, " irq"}, 8'(irq), 8'(v.eirq));
  endtask

  vec_t tbl[$];
  logic [8:0] q[$];

  initial begin
    logic       last;
    logic [7:0] erd;
    logic       kv, uv, gk, gu, addr, pop;
    int         ki, ui, c;

    // Single keyboard byte, then the round-robin fill/drain.
    tbl.push_back(mk(1, 1, 8'h41, 1, 8'h31, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h41, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h01, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h41, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h61, 1, 8'h31, 0, 0, 0, 0, 8'h00, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 8'h61, 1, 8'h31, 0, 0,
                       PRIO | (i % 2 == 0), !PRIO & (i % 2 == 1), 8'h00, 1));
    tbl.push_back(mk(0, 1, 8'h61, 1, 8'h31, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 8'h61, 1, 8'h31, 1, 0, 0, 0, 8'h03, 1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0,
                       (PRIO || i % 2 == 0) ? 8'h61 : 8'h31, i < 7));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

    // Full FIFO with UART waiting: the freed slot is granted one cycle later.
    run(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0), "full_rst");
    for (int i = 0; i < 8; i++)
      run(mk(0, 1, 8'(8'h10 + i), 0, 8'h00, 0, 0, 1, 0, 8'h00, 1), $sformatf("full_fill%0d", i));
    run(mk(0, 0, 8'h00, 1, 8'hA5, 1, 1, 0, 0, 8'h10, 1), "full_popN");
    run(mk(0, 0, 8'h00, 1, 8'hA5, 0, 0, 0, 1, 8'h10, 1), "full_pushN1");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h03, 1), "full_stat");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h11, 1), "full_rd11");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h05, 1), "almost_stat");
    for (int i = 2; i < 8; i++)
      run(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'(8'h10 + i), 1), $sformatf("full_rd%0d", i));
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h81, 1), "uart_head_stat");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'hA5, 0), "uart_head_rd");

    // Simultaneous push and pop at count 3, then empty read.
    for (int i = 1; i < 4; i++)
      run(mk(0, 1, 8'(i), 0, 8'h00, 0, 0, 1, 0, 8'hA5, 1), $sformatf("pp_fill%0d", i));
    run(mk(0, 1, 8'h04, 0, 8'h00, 1, 1, 1, 0, 8'h01, 1), "pp_both");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h02, 1), "pp_rd2");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h03, 1), "pp_rd3");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h04, 0), "pp_rd4");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0), "empty_rd");
    run(mk(0, 0, 8'h00, 1, 8'h5A, 0, 0, 0, 1, 8'h00, 1), "after_empty_push");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h81, 1), "after_empty_stat");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h5A, 0), "after_empty_rd");
    run(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0), "after_empty_stat2");

    // Wrap test: 3*DEPTH bytes, alternating STATUS/DATA reads against a queue model.
    run(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0), "wrap_rst");
    last = 1'b1; erd = 8'h00; ki = 0; ui = 0; c = 0;
    while ((ki < 12 || ui < 12 || q.size() > 0) && c < 400) begin
      kv = (ki < 12);
      uv = (ui < 12);
      addr = c[0];
      gk = 1'b0; gu = 1'b0;
      if (q.size() < DEPTH) begin
        if (PRIO) begin
          gk = kv; gu = uv & ~kv;
        end else begin
          gk = kv & (~uv | last);
          gu = uv & (~kv | ~last);
        end
      end
      if (!addr)
        erd = {(q.size() > 0) ? q[0][8] : 1'b0, 4'b0000, q.size() == DEPTH - 1,
               q.size() == DEPTH, q.size() > 0};
      else
        erd = (q.size() > 0) ? q[0][7:0] : 8'h00;
      pop = addr && (q.size() > 0);
      if (pop) void'(q.pop_front());
      run(mk(0, kv, 8'(8'h80 + ki), uv, 8'(8'hC0 + ui), 1, addr, gk, gu, erd, 1'b0 | 1'b0 |
             ((q.size() + int'(gk) + int'(gu)) != 0)), $sformatf("wrap%0d", c));
      if (gk) begin q.push_back({1'b0, 8'(8'h80 + ki)}); ki++; last = 1'b0; end
      if (gu) begin q.push_back({1'b1, 8'(8'hC0 + ui)}); ui++; last = 1'b1; end
      c++;
    end
    chk("wrap_complete", 8'(c < 400), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
